// File: rtl/link_fifo_path.sv
// link_fifo_path: byte link receiver. A sender hands bytes over with a
// 4-phase rx_sent/rx_ack handshake. Each accepted byte updates a CRC-8,
// a parity-error counter and a last-byte register, then is queued in a
// DEPTH x 8 FIFO. An egress machine drains the FIFO one byte at a time
// toward a transmitter that reports completion on tx_done.
//
// Handshake semantics:
//   ingress (4-phase): the sender raises rx_sent with rx_data stable; the
//   byte is taken once rx_ack rises; the sender then drops rx_sent and
//   rx_ack follows it low. A new byte may only be offered after rx_ack is
//   low again. While the FIFO is full rx_ack stays low and the byte waits.
//   egress: out_start is a one-cycle request with out_data valid from that
//   cycle on; out_data holds until the transmitter answers with tx_done,
//   and only then may the next byte be loaded.
module link_fifo_path #(
  parameter int DEPTH = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_sent,
  output logic       rx_ack,
  input  logic       tx_done,
  output logic [7:0] out_data,
  output logic       out_start,
  output logic [7:0] crc,
  output logic [3:0] err_count,
  output logic [7:0] last_byte,
  output logic [9:0] fifo_count,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic [1:0] ingStateDbg,
  output logic [1:0] egStateDbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ING_IDLE    = 2'd0,
    ING_CAPTURE = 2'd1,
    ING_ACK     = 2'd2
  } ingState_t;

  typedef enum logic [1:0] {
    EG_IDLE = 2'd0,
    EG_READ = 2'd1,
    EG_LOAD = 2'd2,
    EG_WAIT = 2'd3
  } egState_t;

  ingState_t ingState;
  egState_t  egState;

  logic          rxSentMeta;
  logic          rxSentSync;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [7:0]    rdData;
  logic          fifoEmpty;
  logic          fifoFull;
  logic          doWr;
  logic          doRd;

  // CRC-8, polynomial 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8Next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign fifoEmpty  = (count == '0);
  assign fifoFull   = (count == FULL_COUNT);
  assign fifo_empty = fifoEmpty;
  assign fifo_full  = fifoFull;
  assign fifo_count = 10'(count);

  // A write only happens in CAPTURE, a read only in READ; either is dropped
  // when illegal so pointers and occupancy never move on a blocked access.
  assign doWr = enable && (ingState == ING_CAPTURE) && !fifoFull;
  assign doRd = enable && (egState == EG_READ) && !fifoEmpty;

  assign ingStateDbg = ingState;
  assign egStateDbg  = egState;

  // Two-flop synchronizer for the asynchronous sender strobe; cleared in
  // reset so a strobe seen during reset cannot leak into the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxSentMeta <= 1'b0;
      rxSentSync <= 1'b0;
    end else begin
      rxSentMeta <= rx_sent;
      rxSentSync <= rxSentMeta;
    end
  end

  // Ingress handshake: capture one byte per rx_sent pulse, then hold the
  // acknowledge until the sender releases its strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ingState  <= ING_IDLE;
      rx_ack    <= 1'b0;
      crc       <= 8'h00;
      err_count <= 4'h0;
      last_byte <= 8'h00;
    end else if (enable) begin
      case (ingState)
        ING_IDLE: begin
          if (rxSentSync && !fifoFull) ingState <= ING_CAPTURE;
        end
        ING_CAPTURE: begin
          crc       <= crc8Next(crc, rx_data);
          last_byte <= rx_data;
          if ((^rx_data) && (err_count != 4'hF)) err_count <= err_count + 4'h1;
          rx_ack    <= 1'b1;
          ingState  <= ING_ACK;
        end
        ING_ACK: begin
          if (!rxSentSync) begin
            rx_ack   <= 1'b0;
            ingState <= ING_IDLE;
          end
        end
        default: ingState <= ING_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= rx_data;
  end

  // FIFO pointers, occupancy and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      rdData <= 8'h00;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) begin
        rdPtr  <= rdPtr + 1'b1;
        rdData <= mem[rdPtr];
      end
      case ({doWr, doRd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Egress: read one byte, present it with a one-cycle start pulse, and
  // wait for the transmitter before taking the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      egState   <= EG_IDLE;
      out_start <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      out_start <= 1'b0;
      if (enable) begin
        case (egState)
          EG_IDLE: if (!fifoEmpty) egState <= EG_READ;
          EG_READ: egState <= EG_LOAD;
          EG_LOAD: begin
            out_data  <= rdData;
            out_start <= 1'b1;
            egState   <= EG_WAIT;
          end
          EG_WAIT: if (tx_done) egState <= EG_IDLE;
          default: egState <= EG_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_link_fifo_path.sv
// tb_link_fifo_path: directed bench for link_fifo_path. Accepted bytes are
// queued as expectations and checked when the egress side pulses out_start.
module tb_link_fifo_path;

  localparam int DEPTH = 512;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_sent;
  logic       rx_ack;
  logic       tx_done;
  logic [7:0] out_data;
  logic       out_start;
  logic [7:0] crc;
  logic [3:0] err_count;
  logic [7:0] last_byte;
  logic [9:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic [1:0] ing_state_dbg;
  logic [1:0] eg_state_dbg;

  link_fifo_path #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx_data     (rx_data),
    .rx_sent     (rx_sent),
    .rx_ack      (rx_ack),
    .tx_done     (tx_done),
    .out_data    (out_data),
    .out_start   (out_start),
    .crc         (crc),
    .err_count   (err_count),
    .last_byte   (last_byte),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .ingStateDbg (ing_state_dbg),
    .egStateDbg  (eg_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_starts = 0;
  logic [7:0] m_crc    = 8'h00;
  logic [3:0] m_err    = 4'h0;
  logic [7:0] m_last   = 8'h00;
  bit         auto_tx  = 1'b0;
  bit         man_pulse = 1'b0;
  bit         saw_start = 1'b0;
  logic       prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bit-serial reference CRC-8 (poly 0x07, MSB first).
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic model_accept(input logic [7:0] b);
    m_crc  = crc_ref(m_crc, b);
    m_last = b;
    if ((^b) && (m_err != 4'hF)) m_err = m_err + 4'h1;
    exp_q.push_back(b);
  endtask

  // Transmitter model: answers each out_start with a tx_done pulse when in
  // auto mode; man_pulse requests a single tx_done pulse.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (man_pulse) begin
      tx_done   = 1'b1;
      man_pulse = 1'b0;
    end else if (auto_tx && saw_start) begin
      tx_done = 1'b1;
    end
    saw_start = out_start;
  end

  // Egress monitor: pop and compare on every out_start.
  always @(negedge clk) begin
    if (!reset && out_start) begin
      n_starts++;
      check("start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) check("scb_unexpected_start", 32'd1, 32'd0);
      else check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
    prev_start = out_start;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input logic level, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rx_ack === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    rx_data = b;
    rx_sent = 1'b1;
    wait_ack(1'b1, 40, ok);
    if (!ok) check("ack_rise_timeout", 32'd0, 32'd1);
    else begin
      model_accept(b);
      check("crc", {24'd0, crc}, {24'd0, m_crc});
      check("err_count", {28'd0, err_count}, {28'd0, m_err});
      check("last_byte", {24'd0, last_byte}, {24'd0, m_last});
    end
    rx_sent = 1'b0;
    wait_ack(1'b0, 40, ok);
    if (!ok) check("ack_fall_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    rx_sent = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    m_crc  = 8'h00;
    m_err  = 4'h0;
    m_last = 8'h00;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (fifo_empty && exp_q.size() == 0 && eg_state_dbg == 2'd0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit         ok;
    logic [7:0] r;
    int         starts0;

    reset   = 1'b1;
    enable  = 1'b1;
    rx_data = 8'h00;
    rx_sent = 1'b1;

    // Reset with the strobe high, then flush it before release.
    repeat (2) @(negedge clk);
    check("ack_in_reset", {31'd0, rx_ack}, 32'd0);
    rx_sent = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
    check("rst_out_start", {31'd0, out_start}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_crc", {24'd0, crc}, 32'd0);
    check("rst_err_count", {28'd0, err_count}, 32'd0);
    check("rst_last_byte", {24'd0, last_byte}, 32'd0);
    check("rst_fifo_count", {22'd0, fifo_count}, 32'd0);
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);

    // Single byte 0x33: known CRC, and out_start three edges after the
    // FIFO turns non-empty (same edge that raises rx_ack).
    auto_tx = 1'b0;
    rx_data = 8'h33;
    rx_sent = 1'b1;
    wait_ack(1'b1, 40, ok);
    if (!ok) check("ack33_timeout", 32'd0, 32'd1);
    model_accept(8'h33);
    check("crc_33", {24'd0, crc}, 32'h99);
    check("err_33", {28'd0, err_count}, 32'd0);
    check("last_33", {24'd0, last_byte}, 32'h33);
    check("empty_after_33", {31'd0, fifo_empty}, 32'd0);
    rx_sent = 1'b0;
    @(negedge clk);
    check("start_lat_e1", {31'd0, out_start}, 32'd0);
    @(negedge clk);
    check("start_lat_e2", {31'd0, out_start}, 32'd0);
    @(negedge clk);
    check("start_lat_e3", {31'd0, out_start}, 32'd1);
    check("out_data_33", {24'd0, out_data}, 32'h33);
    wait_ack(1'b0, 40, ok);
    if (!ok) check("ack33_fall_timeout", 32'd0, 32'd1);
    man_pulse = 1'b1;
    wait_drain(50);

    // Parity errors: 0x01 then 20 odd-parity bytes saturate the counter.
    auto_tx = 1'b1;
    send_byte(8'h01);
    check("err_after_01", {28'd0, err_count}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom_range(0, 255));
      if (^r == 1'b0) r[0] = ~r[0];
      send_byte(r);
    end
    check("err_saturated", {28'd0, err_count}, 32'd15);
    wait_drain(500);

    // In-order delivery of a burst with the transmitter answering.
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    wait_drain(200);
    check("empty_after_burst", {31'd0, fifo_empty}, 32'd1);

    // Fill: DEPTH+1 bytes with the transmitter stalled.
    auto_tx = 1'b0;
    starts0 = n_starts;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom_range(0, 255)));
    check("fill_count", {22'd0, fifo_count}, DEPTH);
    check("fill_full", {31'd0, fifo_full}, 32'd1);
    check("fill_one_in_egress", n_starts - starts0, 32'd1);

    // Blocked byte while full, released by one tx_done.
    rx_data = 8'h5C;
    rx_sent = 1'b1;
    repeat (12) @(negedge clk);
    check("full_ack_low", {31'd0, rx_ack}, 32'd0);
    check("full_count_held", {22'd0, fifo_count}, DEPTH);
    man_pulse = 1'b1;
    wait_ack(1'b1, 40, ok);
    if (!ok) check("blocked_ack_timeout", 32'd0, 32'd1);
    else model_accept(8'h5C);
    check("blocked_last_byte", {24'd0, last_byte}, 32'h5C);
    check("blocked_crc", {24'd0, crc}, {24'd0, m_crc});
    rx_sent = 1'b0;
    wait_ack(1'b0, 40, ok);
    if (!ok) check("blocked_fall_timeout", 32'd0, 32'd1);
    check("refill_count", {22'd0, fifo_count}, DEPTH);
    check("refill_full", {31'd0, fifo_full}, 32'd1);

    // Reset mid-handshake with bytes queued.
    do_reset();
    check("clean_count", {22'd0, fifo_count}, 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h44);
    rx_data = 8'h88;
    rx_sent = 1'b1;
    wait_ack(1'b1, 40, ok);
    if (!ok) check("mid_ack_timeout", 32'd0, 32'd1);
    check("queued_before_reset", {22'd0, fifo_count}, 32'd3);
    reset   = 1'b1;
    rx_sent = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rx_ack", {31'd0, rx_ack}, 32'd0);
    check("midrst_fifo_count", {22'd0, fifo_count}, 32'd0);
    check("midrst_crc", {24'd0, crc}, 32'd0);
    check("midrst_out_start", {31'd0, out_start}, 32'd0);
    check("midrst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_count", {22'd0, fifo_count}, 32'd0);
    check("post_rst_eg_idle", {30'd0, eg_state_dbg}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
